// File: rtl/ctrl_seq.sv
// Instruction sequencer: owns pc/ir and runs fetch/decode/execute over a
// ready-handshaked program memory, with conditional jumps and I/O stalls.
module ctrl_seq #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic [PC_W-1:0] mem_addr,
  output logic            mem_rd,
  input  logic            mem_rdy,
  input  logic [7:0]      mem_data,
  input  logic            zero,
  input  logic            carry,
  input  logic            io_rdy,
  output logic [7:0]      ir,
  output logic [PC_W-1:0] pc,
  output logic            fetch,
  output logic            decode,
  output logic            execute
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_OPERAND,
    S_DECODE,
    S_EXECUTE
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1001;
  localparam logic [3:0] OP_INP  = 4'b1010;
  localparam logic [3:0] OP_OUTP = 4'b1110;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      target_q, target_d;

  logic [3:0]      opcode;
  logic            is_jump;
  logic            cond_met;
  logic [PC_W-1:0] target_pc;

  assign opcode  = ir_q[7:4];
  assign is_jump = (opcode == OP_JMP) || (opcode == OP_JC);

  // The operand byte is always 8 bits wide; fit it to the pc width.
  generate
    if (PC_W > 8) begin : g_target_ext
      assign target_pc = {{(PC_W-8){1'b0}}, target_q};
    end else if (PC_W == 8) begin : g_target_eq
      assign target_pc = target_q;
    end else begin : g_target_trunc
      assign target_pc = target_q[PC_W-1:0];
    end
  endgenerate

  always_comb begin
    cond_met = 1'b0;
    case (ir_q[3:2])
      2'b00:   cond_met = zero;
      2'b01:   cond_met = ~zero;
      2'b10:   cond_met = carry;
      default: cond_met = ~carry;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= 8'h00;
      target_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    target_d = target_q;
    case (state_q)
      S_FETCH: begin
        if (run && mem_rdy) begin
          ir_d    = mem_data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = is_jump ? S_OPERAND : S_EXECUTE;
      end
      S_OPERAND: begin
        if (mem_rdy) begin
          target_d = mem_data;
          pc_d     = pc_q + PC_ONE;
          state_d  = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_JMP: begin
            pc_d    = target_pc;
            state_d = S_FETCH;
          end
          OP_JC: begin
            if (cond_met) begin
              pc_d = target_pc;
            end
            state_d = S_FETCH;
          end
          OP_INP, OP_OUTP: begin
            if (io_rdy) begin
              state_d = S_FETCH;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end
      default: state_d = S_FETCH;
    endcase
  end

  // OPERAND keeps decode high while it reads the second byte.
  always_comb begin
    fetch    = (state_q == S_FETCH) && run;
    mem_rd   = fetch || (state_q == S_OPERAND);
    decode   = (state_q == S_DECODE) || (state_q == S_OPERAND);
    execute  = (state_q == S_EXECUTE);
    mem_addr = pc_q;
    pc       = pc_q;
    ir       = ir_q;
  end

endmodule
